// File: rtl/dds_pkg.sv
// Shared configuration for the DDS LUT scheduler: channel count, datapath
// widths and the per-channel configuration record.
package dds_pkg;

  localparam int NUM_CH  = 4;   // channels sharing the LUT (>=2, power of two)
  localparam int PHASE_W = 10;  // phase accumulator / tuning word width
  localparam int AMP_W   = 10;  // LUT amplitude width
  localparam int CH_W    = $clog2(NUM_CH);

  // Per-channel configuration written over the host bus
  typedef struct packed {
    logic [PHASE_W-1:0] ftw;
    logic               en;
  } ch_cfg_t;

endpackage

// File: rtl/dds_channel_bank.sv
// Per-channel tuning word, enable and phase accumulator registers.
// A single adder advances whichever channel currently owns the LUT slot.
module dds_channel_bank
  import dds_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [CH_W-1:0]    wr_ch,
  input  ch_cfg_t            wr_cfg,
  input  logic               wr_clr,
  input  logic               sync,
  input  logic [CH_W-1:0]    slot,
  output logic [PHASE_W-1:0] slot_phase,
  output logic               slot_en
);

  logic [PHASE_W-1:0] acc_all [NUM_CH];
  logic [PHASE_W-1:0] ftw_all [NUM_CH];
  logic               en_all  [NUM_CH];
  logic [PHASE_W-1:0] next_phase;

  // The slot channel's current phase goes to the LUT; its sum is the only
  // accumulator update that can happen this cycle, so one adder suffices.
  assign slot_phase = acc_all[slot];
  assign slot_en    = en_all[slot];
  assign next_phase = acc_all[slot] + ftw_all[slot];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ch_cfg_t            cfg_reg;
      logic [PHASE_W-1:0] acc_reg;
      logic               hit_wr;
      logic               hit_slot;

      assign hit_wr   = wr_en && (wr_ch == CH_W'(gi));
      assign hit_slot = (slot == CH_W'(gi));

      assign acc_all[gi] = acc_reg;
      assign ftw_all[gi] = cfg_reg.ftw;
      assign en_all[gi]  = cfg_reg.en;

      // Config write lands at end of cycle, so a write in this channel's own
      // slot still lets the slot use the old ftw/en.
      always_ff @(posedge clk) begin
        if (reset) begin
          cfg_reg <= '0;
        end else if (hit_wr) begin
          cfg_reg <= wr_cfg;
        end
      end

      // Accumulator priority: sync clears all, then per-channel clear, then increment.
      always_ff @(posedge clk) begin
        if (reset || sync) begin
          acc_reg <= '0;
        end else if (hit_wr && wr_clr) begin
          acc_reg <= '0;
        end else if (hit_slot && cfg_reg.en) begin
          acc_reg <= next_phase;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/dds_lut_scheduler.sv
// Round-robin scheduler sharing one combinational sine LUT among NUM_CH DDS
// channels: one channel per clock presents its phase, the returned amplitude
// is registered and tagged with its channel one cycle later.
module dds_lut_scheduler
  import dds_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [PHASE_W-1:0] cfg_ftw,
  input  logic               cfg_en,
  input  logic               cfg_clr,
  input  logic               sync_req,
  output logic [PHASE_W-1:0] lut_phase,
  input  logic [AMP_W-1:0]   lut_data,
  output logic               out_valid,
  output logic [CH_W-1:0]    out_ch,
  output logic [AMP_W-1:0]   out_sample
);

  logic [CH_W-1:0]  slot_reg;
  logic             cfg_ready_reg;
  logic             out_valid_reg;
  logic [CH_W-1:0]  out_ch_reg;
  logic [AMP_W-1:0] out_sample_reg;
  logic             wr_en;
  logic             slot_en;
  ch_cfg_t          wr_cfg;

  assign wr_en  = cfg_valid && cfg_ready_reg;
  assign wr_cfg = '{ftw: cfg_ftw, en: cfg_en};

  dds_channel_bank u_bank (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_ch      (cfg_ch),
    .wr_cfg     (wr_cfg),
    .wr_clr     (cfg_clr),
    .sync       (sync_req),
    .slot       (slot_reg),
    .slot_phase (lut_phase),
    .slot_en    (slot_en)
  );

  // Free-running slot counter; NUM_CH is a power of two so it wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_reg <= '0;
    end else begin
      slot_reg <= slot_reg + CH_W'(1);
    end
  end

  // Config port is ready from the cycle after the first non-reset edge onward.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_ready_reg <= 1'b0;
    end else begin
      cfg_ready_reg <= 1'b1;
    end
  end

  // Capture the LUT result for the current slot; valid follows that slot's enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      out_ch_reg     <= '0;
      out_sample_reg <= '0;
    end else begin
      out_valid_reg  <= slot_en;
      out_ch_reg     <= slot_reg;
      out_sample_reg <= lut_data;
    end
  end

  assign cfg_ready  = cfg_ready_reg;
  assign out_valid  = out_valid_reg;
  assign out_ch     = out_ch_reg;
  assign out_sample = out_sample_reg;

endmodule

// File: tb/tb_dds_lut_scheduler.sv
// Scoreboard bench for dds_lut_scheduler: a behavioural channel model queues
// the expected output for every clock; a negedge monitor pops and compares.
module tb_dds_lut_scheduler;
  import dds_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CH_W-1:0]    cfg_ch;
  logic [PHASE_W-1:0] cfg_ftw;
  logic               cfg_en;
  logic               cfg_clr;
  logic               sync_req;
  logic [PHASE_W-1:0] lut_phase;
  logic [AMP_W-1:0]   lut_data;
  logic               out_valid;
  logic [CH_W-1:0]    out_ch;
  logic [AMP_W-1:0]   out_sample;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dds_lut_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_ftw    (cfg_ftw),
    .cfg_en     (cfg_en),
    .cfg_clr    (cfg_clr),
    .sync_req   (sync_req),
    .lut_phase  (lut_phase),
    .lut_data   (lut_data),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .out_sample (out_sample)
  );

  // Random-content LUT indexed by the full phase so any phase error shows up.
  logic [AMP_W-1:0] lut_table [1 << PHASE_W];
  assign lut_data = lut_table[lut_phase];

  // Behavioural model state
  logic [PHASE_W-1:0] m_acc [NUM_CH];
  logic [PHASE_W-1:0] m_ftw [NUM_CH];
  bit                 m_en  [NUM_CH];
  int                 m_slot;
  bit                 m_ready;
  bit                 started = 0;

  typedef struct {
    bit               v;
    bit               is_rst;
    logic [CH_W-1:0]  ch;
    logic [AMP_W-1:0] s;
  } exp_t;
  exp_t exp_q[$];

  // Model: each clock one channel in turn emits its current phase, then the
  // clock's config/clear/sync effects are applied in priority order.
  always @(posedge clk) begin
    exp_t e;
    int   k;
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_acc[i] = '0;
        m_ftw[i] = '0;
        m_en[i]  = 0;
      end
      m_slot  = 0;
      m_ready = 0;
      exp_q.delete();
      e = '{v: 0, is_rst: 1, ch: '0, s: '0};
      exp_q.push_back(e);
    end else begin
      k = m_slot;
      e = '{v: m_en[k], is_rst: 0, ch: CH_W'(k), s: lut_table[m_acc[k]]};
      exp_q.push_back(e);
      if (m_en[k]) m_acc[k] = m_acc[k] + m_ftw[k];
      if (cfg_valid && m_ready) begin
        m_ftw[cfg_ch] = cfg_ftw;
        m_en[cfg_ch]  = cfg_en;
        if (cfg_clr) m_acc[cfg_ch] = '0;
      end
      if (sync_req) begin
        for (int i = 0; i < NUM_CH; i++) m_acc[i] = '0;
      end
      m_slot  = (m_slot + 1) % NUM_CH;
      m_ready = 1;
    end
    started = 1;
  end

  // Monitor: compare DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      checks++;
      if (cfg_ready !== m_ready) begin
        errors++;
        $display("FAIL cfg_ready: got %0b expected %0b at %0t", cfg_ready, m_ready, $time);
      end
      checks++;
      if (lut_phase !== m_acc[m_slot]) begin
        errors++;
        $display("FAIL lut_phase slot %0d: got %0h expected %0h at %0t", m_slot, lut_phase, m_acc[m_slot], $time);
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got no expectation for output at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== e.v) begin
          errors++;
          $display("FAIL out_valid: got %0b expected %0b (ch %0d) at %0t", out_valid, e.v, e.ch, $time);
        end else if (e.v || e.is_rst) begin
          checks++;
          if (out_ch !== e.ch || out_sample !== e.s) begin
            errors++;
            $display("FAIL sample: got ch %0d sample %0h expected ch %0d sample %0h at %0t", out_ch, out_sample, e.ch, e.s, $time);
          end
        end
        if (e.v) $display("sample ch %0d amp %0h at %0t", out_ch, out_sample, $time);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_write(input int ch, input int ftw, input bit en, input bit clr);
    cfg_ch    = CH_W'(ch);
    cfg_ftw   = PHASE_W'(ftw);
    cfg_en    = en;
    cfg_clr   = clr;
    cfg_valid = 1'b1;
    $display("cfg write ch %0d ftw %0h en %0b clr %0b", ch, ftw, en, clr);
    step(1);
    cfg_valid = 1'b0;
    cfg_clr   = 1'b0;
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << PHASE_W); i++) lut_table[i] = AMP_W'($urandom);
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_ftw   = '0;
    cfg_en    = 1'b0;
    cfg_clr   = 1'b0;
    sync_req  = 1'b0;
    step(3);
    reset = 1'b0;
    step(2);

    // ch0 ftw=4: phases 0,4,8,12...
    do_write(0, 4, 1, 0);
    step(16);
    // ch1 ftw=0x300: wrapping sequence
    do_write(1, 'h300, 1, 0);
    step(24);
    // ch2 with ftw=3, then rewrite to 8 inside ch2's own slot
    do_write(2, 3, 1, 0);
    step(9);
    while (m_slot != 2) step(1);
    do_write(2, 8, 1, 0);
    step(12);
    // all four running, then sync, then clear ch3 only
    do_write(3, 'h55, 1, 0);
    step(13);
    sync_req = 1'b1;
    $display("sync pulse");
    step(1);
    sync_req = 1'b0;
    step(10);
    do_write(3, 'h55, 1, 1);
    step(10);
    // disable and re-enable ch1
    do_write(1, 'h300, 0, 0);
    step(16);
    do_write(1, 'h300, 1, 0);
    step(12);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = CH_W'($urandom);
      cfg_ftw   = PHASE_W'($urandom);
      cfg_en    = ($urandom_range(0, 4) != 0);
      cfg_clr   = ($urandom_range(0, 5) == 0);
      sync_req  = ($urandom_range(0, 30) == 0);
      step(1);
    end
    cfg_valid = 1'b0;
    cfg_clr   = 1'b0;
    sync_req  = 1'b0;
    step(7);

    // reset mid-stream, with a write attempted right after release
    reset = 1'b1;
    $display("mid-stream reset");
    step(1);
    reset     = 1'b0;
    cfg_valid = 1'b1;
    cfg_ch    = '0;
    cfg_ftw   = PHASE_W'(7);
    cfg_en    = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    step(4);
    do_write(2, 'h11, 1, 0);
    step(16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
